// File: rtl/alu_arbiter_pkg.sv
// Shared project definitions for the ALU arbiter: default widths, opcode
// values and FSM state encoding.
// Optional feature macro used by alu_arbiter: ALU_ARB_ROUND_ROBIN_EN.
package alu_arbiter_pkg;

  localparam int PRJ_DATA_WIDTH = 32;
  localparam int PRJ_OPRN_WIDTH = 6;

  localparam int OP_ADD = 1;
  localparam int OP_SUB = 2;
  localparam int OP_MUL = 3;
  localparam int OP_SHR = 4;
  localparam int OP_SHL = 5;
  localparam int OP_AND = 6;
  localparam int OP_OR  = 7;
  localparam int OP_NOR = 8;
  localparam int OP_SLT = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU shared by both requesters. Opcodes outside the
// supported set produce zero; flagging them as errors is the arbiter's job.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = PRJ_DATA_WIDTH,
  parameter int OPRN_WIDTH = PRJ_OPRN_WIDTH
) (
  output logic [DATA_WIDTH-1:0] result,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [OPRN_WIDTH-1:0] oprn
);

  // Opcode decode; shifts use the full op2 value so large amounts give zero.
  always_comb begin
    result = '0;
    case (oprn)
      OPRN_WIDTH'(OP_ADD): result = op1 + op2;
      OPRN_WIDTH'(OP_SUB): result = op1 - op2;
      OPRN_WIDTH'(OP_MUL): result = op1 * op2;
      OPRN_WIDTH'(OP_SHR): result = op1 >> op2;
      OPRN_WIDTH'(OP_SHL): result = op1 << op2;
      OPRN_WIDTH'(OP_AND): result = op1 & op2;
      OPRN_WIDTH'(OP_OR):  result = op1 | op2;
      OPRN_WIDTH'(OP_NOR): result = ~(op1 | op2);
      OPRN_WIDTH'(OP_SLT): result = {{(DATA_WIDTH-1){1'b0}}, (op1 < op2)};
      default:             result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU. One operation in flight;
// accept in cycle t gives the response strobe in cycle t+2.
// Conflict policy: fixed priority to requester 0 by default; define
// ALU_ARB_ROUND_ROBIN_EN to alternate on conflicts.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a request; READY driven for the granted side
// ST_EXEC | registered operands feed the ALU; RESULT/ERR captured
// ST_RESP | RSPn_VALID high for the granted requester, one cycle
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = PRJ_DATA_WIDTH,
  parameter int OPRN_WIDTH = PRJ_OPRN_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0_VALID,
  input  logic                  REQ1_VALID,
  output logic                  REQ0_READY,
  output logic                  REQ1_READY,
  input  logic [DATA_WIDTH-1:0] REQ0_OP1,
  input  logic [DATA_WIDTH-1:0] REQ0_OP2,
  input  logic [DATA_WIDTH-1:0] REQ1_OP1,
  input  logic [DATA_WIDTH-1:0] REQ1_OP2,
  input  logic [OPRN_WIDTH-1:0] REQ0_OPRN,
  input  logic [OPRN_WIDTH-1:0] REQ1_OPRN,
  output logic                  RSP0_VALID,
  output logic                  RSP1_VALID,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  ERR
);

  state_t                state;
  logic [DATA_WIDTH-1:0] op1_q;
  logic [DATA_WIDTH-1:0] op2_q;
  logic [OPRN_WIDTH-1:0] oprn_q;
  logic                  gnt_q;
  logic                  rsp0_q;
  logic                  rsp1_q;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  grant_sel;
  logic                  accept;
  logic                  oprn_illegal;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_q;

  // On a conflict, whoever was not granted last wins.
  always_comb begin
    grant_sel = REQ1_VALID && (!REQ0_VALID || !last_q);
  end

  // Pointer remembers the most recent grant; reset value favours requester 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant_sel;
    end
  end
`else
  // Requester 0 has fixed priority.
  always_comb begin
    grant_sel = REQ1_VALID && !REQ0_VALID;
  end
`endif

  assign accept     = (state == ST_IDLE) && !RST && (REQ0_VALID || REQ1_VALID);
  assign REQ0_READY = (state == ST_IDLE) && !RST && REQ0_VALID && !grant_sel;
  assign REQ1_READY = (state == ST_IDLE) && !RST && REQ1_VALID && grant_sel;
  assign RSP0_VALID = rsp0_q && !RST;
  assign RSP1_VALID = rsp1_q && !RST;

  assign oprn_illegal = (oprn_q < OPRN_WIDTH'(OP_ADD)) || (oprn_q > OPRN_WIDTH'(OP_SLT));

  alu #(
    .DATA_WIDTH(DATA_WIDTH),
    .OPRN_WIDTH(OPRN_WIDTH)
  ) u_alu (
    .result(alu_result),
    .op1   (op1_q),
    .op2   (op2_q),
    .oprn  (oprn_q)
  );

  // Control FSM with registered operands, result, error flag and response strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      op1_q  <= '0;
      op2_q  <= '0;
      oprn_q <= '0;
      gnt_q  <= 1'b0;
      RESULT <= '0;
      ERR    <= 1'b0;
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rsp0_q <= 1'b0;
          rsp1_q <= 1'b0;
          if (accept) begin
            op1_q  <= grant_sel ? REQ1_OP1  : REQ0_OP1;
            op2_q  <= grant_sel ? REQ1_OP2  : REQ0_OP2;
            oprn_q <= grant_sel ? REQ1_OPRN : REQ0_OPRN;
            gnt_q  <= grant_sel;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          RESULT <= oprn_illegal ? '0 : alu_result;
          ERR    <= oprn_illegal;
          rsp0_q <= !gnt_q;
          rsp1_q <= gnt_q;
          state  <= ST_RESP;
        end
        ST_RESP: begin
          rsp0_q <= 1'b0;
          rsp1_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          rsp0_q <= 1'b0;
          rsp1_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a transaction-level reference model:
// grants follow the conflict rule, each accepted operation answers two
// cycles later, RESULT/ERR hold between operations.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int OW = 6;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic          REQ0_READY, REQ1_READY;
  logic [DW-1:0] REQ0_OP1 = '0, REQ0_OP2 = '0, REQ1_OP1 = '0, REQ1_OP2 = '0;
  logic [OW-1:0] REQ0_OPRN = '0, REQ1_OPRN = '0;
  logic          RSP0_VALID, RSP1_VALID;
  logic [DW-1:0] RESULT;
  logic          ERR;

  always #5 CLK = ~CLK;

  alu_arbiter #(.DATA_WIDTH(DW), .OPRN_WIDTH(OW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ1_VALID(REQ1_VALID),
    .REQ0_READY(REQ0_READY), .REQ1_READY(REQ1_READY),
    .REQ0_OP1(REQ0_OP1), .REQ0_OP2(REQ0_OP2),
    .REQ1_OP1(REQ1_OP1), .REQ1_OP2(REQ1_OP2),
    .REQ0_OPRN(REQ0_OPRN), .REQ1_OPRN(REQ1_OPRN),
    .RSP0_VALID(RSP0_VALID), .RSP1_VALID(RSP1_VALID),
    .RESULT(RESULT), .ERR(ERR)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic on 64-bit integers, truncated to the data width.
  function automatic void ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input int op, output logic [DW-1:0] r, output logic e);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    e = 1'b0;
    case (op)
      1: r = DW'(ua + ub);
      2: r = DW'(ua - ub);
      3: r = DW'(ua * ub);
      4: r = (ub >= 64'(DW)) ? '0 : DW'(ua >> ub);
      5: r = (ub >= 64'(DW)) ? '0 : DW'(ua << ub);
      6: r = a & b;
      7: r = a | b;
      8: r = ~(a | b);
      9: r = (ua < ub) ? DW'(1) : DW'(0);
      default: begin r = '0; e = 1'b1; end
    endcase
  endfunction

  // Model state
  int            cyc = 0;
  int            next_free = 0;
  int            rsp_cyc = -1;
  int            rsp_id = 0;
  int            last_gnt = 1;
  int            acc_win = -1;
  logic [DW-1:0] cur_res = '0, pend_res = '0;
  logic          cur_err = 1'b0, pend_err = 1'b0;
  logic [DW-1:0] m_op1 [2];
  logic [DW-1:0] m_op2 [2];
  logic [OW-1:0] m_opr [2];
  int            grant_log[$];

  task automatic issue(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [OW-1:0] op);
    m_op1[id] = a; m_op2[id] = b; m_opr[id] = op;
    if (id == 0) begin
      REQ0_OP1 = a; REQ0_OP2 = b; REQ0_OPRN = op; REQ0_VALID = 1'b1;
    end else begin
      REQ1_OP1 = a; REQ1_OP2 = b; REQ1_OPRN = op; REQ1_VALID = 1'b1;
    end
  endtask

  // One clock: check at negedge, advance model, then step past the posedge.
  task automatic cycle();
    int win;
    @(negedge CLK);
    win = -1;
    if (RST) begin
      check("ready0_in_reset", REQ0_READY, 1'b0);
      check("ready1_in_reset", REQ1_READY, 1'b0);
      check("rsp0_in_reset", RSP0_VALID, 1'b0);
      check("rsp1_in_reset", RSP1_VALID, 1'b0);
      cur_res = '0; cur_err = 1'b0; rsp_cyc = -1; next_free = cyc + 1; last_gnt = 1;
    end else begin
      if (cyc == rsp_cyc) begin
        cur_res = pend_res; cur_err = pend_err;
      end
      if (cyc >= next_free) begin
        if (REQ0_VALID && REQ1_VALID) win = (RR && last_gnt == 0) ? 1 : 0;
        else if (REQ0_VALID) win = 0;
        else if (REQ1_VALID) win = 1;
      end
      check("ready0", REQ0_READY, win == 0);
      check("ready1", REQ1_READY, win == 1);
      check("rsp0", RSP0_VALID, (cyc == rsp_cyc) && (rsp_id == 0));
      check("rsp1", RSP1_VALID, (cyc == rsp_cyc) && (rsp_id == 1));
      check("result", RESULT, cur_res);
      check("err", ERR, cur_err);
      if (win >= 0) begin
        ref_alu(m_op1[win], m_op2[win], int'(m_opr[win]), pend_res, pend_err);
        rsp_cyc = cyc + 2; rsp_id = win; next_free = cyc + 3; last_gnt = win;
        grant_log.push_back(win);
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    acc_win = win;
    if (win == 0) begin REQ0_VALID = 1'b0; REQ0_OP1 = $urandom; end
    if (win == 1) begin REQ1_VALID = 1'b0; REQ1_OP2 = $urandom; end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((REQ0_VALID || REQ1_VALID || cyc < next_free) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_in_budget", n < budget, 1'b1);
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_op1[0] = '0; m_op1[1] = '0; m_op2[0] = '0; m_op2[1] = '0;
    m_opr[0] = '0; m_opr[1] = '0;
    @(posedge CLK); #1;
    do_reset(2);
    cycle();
    check("reset_result", RESULT, '0);
    check("reset_err", ERR, 1'b0);

    // Single requester add, latency checked by the model
    issue(0, 15, 5, 6'h01);
    drain(20);
    check("add_15_5", RESULT, 20);
    check("add_err", ERR, 1'b0);

    // Unsigned set-less-than from requester 1
    issue(1, 15, 20, 6'h09);
    drain(20);
    check("slt_true", RESULT, 1);
    issue(1, 15, 5, 6'h09);
    drain(20);
    check("slt_false", RESULT, 0);

    // NOR and an illegal opcode
    issue(0, 15, 32'hFFFF_FFF0, 6'h08);
    drain(20);
    check("nor_result", RESULT, 32'h0);
    issue(0, 15, 32'hFFFF_FFF0, 6'h0A);
    drain(20);
    check("illegal_result", RESULT, 0);
    check("illegal_err", ERR, 1'b1);

    // Both requesters held valid: grant order depends on the conflict policy
    do_reset(1);
    grant_log.delete();
    issue(0, 3, 4, 6'h01);
    issue(1, 7, 2, 6'h02);
    for (int n = 0; n < 40 && grant_log.size() < 4; n++) begin
      cycle();
      if (acc_win == 0 && grant_log.size() < 4) issue(0, $urandom, $urandom, 6'h03);
      if (acc_win == 1 && grant_log.size() < 4) issue(1, $urandom, $urandom, 6'h07);
    end
    check("grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size())
        check($sformatf("grant_order_%0d", i), grant_log[i], RR ? (i % 2) : 0);
    end
    drain(40);

    // Reset while executing: the in-flight operation must vanish
    issue(0, 100, 23, 6'h01);
    for (int n = 0; n < 10 && acc_win < 0; n++) cycle();
    check("mid_op_accepted", acc_win, 0);
    do_reset(1);
    for (int i = 0; i < 3; i++) cycle();
    check("after_reset_result", RESULT, 0);
    check("after_reset_err", ERR, 1'b0);
    issue(0, 15, 2, 6'h05);
    drain(20);
    check("shl_15_2", RESULT, 60);

    // Randomized traffic with occasional resets
    for (int it = 0; it < 400; it++) begin
      for (int id = 0; id < 2; id++) begin
        logic is_valid;
        is_valid = (id == 0) ? REQ0_VALID : REQ1_VALID;
        if (!is_valid && $urandom_range(0, 9) < 4) begin
          logic [OW-1:0] op;
          logic [DW-1:0] b;
          op = OW'($urandom_range(0, 11));
          b  = $urandom;
          if ((op == 6'h04 || op == 6'h05) && $urandom_range(0, 3) != 0) b = DW'($urandom_range(0, 40));
          if (op == 6'h09 && $urandom_range(0, 1) == 0) b = DW'($urandom_range(0, 3));
          issue(id, $urandom, b, op);
        end else if (!is_valid) begin
          if (id == 0) REQ0_OP1 = $urandom; else REQ1_OPRN = OW'($urandom_range(0, 63));
        end
      end
      RST = ($urandom_range(0, 59) == 0);
      cycle();
    end
    RST = 1'b0;
    drain(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
